stepdown_corestate_seq: RTL and testbench

- Synchronous core-state sequencer for the step-down converter's CORESTATE logic.
- Debounces enable and UVLO, ramps a soft-start reference code, gates switching, and runs over-current hiccup retry.
- Its registered sw_en and run outputs feed the downstream nand2 gate-enable/non-overlap bricks of the same core.

---
 rtl/stepdown_corestate_seq.sv | 139 +++++++++++++
 tb/tb_stepdown_corestate_seq.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stepdown_corestate_seq.sv
// Core-state sequencer for the step-down converter: debounced enable/UVLO,
// soft-start reference ramp, switching gate and over-current hiccup retry.
module stepdown_corestate_seq #(
  parameter int SS_W        = 6,
  parameter int SS_STEP_DIV = 4,
  parameter int DEB_CYC     = 3,
  parameter int OC_LIMIT    = 4,
  parameter int RETRY_CYC   = 64
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            CELV,
  input  logic            CELG,
  input  logic            SUB,
  input  logic            en,
  input  logic            uvlo_ok,
  input  logic            oc,
  output logic [SS_W-1:0] ss_code,
  output logic            sw_en,
  output logic            run,
  output logic            fault,
  output logic [2:0]      state
);

  localparam int DEB_W   = (DEB_CYC     > 1) ? $clog2(DEB_CYC)     : 1;
  localparam int PRE_W   = (SS_STEP_DIV > 1) ? $clog2(SS_STEP_DIV) : 1;
  localparam int OC_W    = (OC_LIMIT    > 1) ? $clog2(OC_LIMIT)    : 1;
  localparam int RETRY_W = (RETRY_CYC   > 1) ? $clog2(RETRY_CYC)   : 1;

  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_CYC - 1);
  localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(SS_STEP_DIV - 1);
  localparam logic [OC_W-1:0]    OC_LAST    = OC_W'(OC_LIMIT - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(RETRY_CYC - 1);
  localparam logic [SS_W-1:0]    SS_MAX     = {SS_W{1'b1}};

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_SOFT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FAULT = 3'd3
  } state_t;

  state_t             state_q, state_d;
  logic [SS_W-1:0]    ss_d;
  logic [DEB_W-1:0]   deb_q, deb_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [OC_W-1:0]    oc_q, oc_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               q;

  // Power and substrate pins exist only for the brick netlist.
  logic unused_pins;
  assign unused_pins = CELV ^ CELG ^ SUB;

  assign q     = en & uvlo_ok;
  assign state = state_q;

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    ss_d    = ss_code;
    pre_d   = pre_q;
    deb_d   = '0;
    oc_d    = '0;
    retry_d = '0;
    unique case (state_q)
      ST_OFF: begin
        ss_d  = '0;
        pre_d = '0;
        if (q) begin
          if (deb_q == DEB_LAST) state_d = ST_SOFT;
          else                   deb_d   = deb_q + DEB_W'(1);
        end
      end
      ST_SOFT, ST_RUN: begin
        if (!q) begin
          state_d = ST_OFF;
          ss_d    = '0;
          pre_d   = '0;
        end else if (oc && (oc_q == OC_LAST)) begin
          // Over-current wins over a coincident soft-start completion.
          state_d = ST_FAULT;
          ss_d    = '0;
          pre_d   = '0;
        end else begin
          oc_d = oc ? oc_q + OC_W'(1) : '0;
          if (state_q == ST_SOFT) begin
            if (pre_q == PRE_LAST) begin
              pre_d = '0;
              if (ss_code == SS_MAX) state_d = ST_RUN;
              else                   ss_d    = ss_code + SS_W'(1);
            end else begin
              pre_d = pre_q + PRE_W'(1);
            end
          end
        end
      end
      ST_FAULT: begin
        ss_d  = '0;
        pre_d = '0;
        if (!q || (retry_q == RETRY_LAST)) state_d = ST_OFF;
        else                               retry_d = retry_q + RETRY_W'(1);
      end
      default: begin
        state_d = ST_OFF;
        ss_d    = '0;
        pre_d   = '0;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // sees the pre-edge values of its peers, exactly like the flops will.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_OFF;
      ss_code <= '0;
      deb_q   <= '0;
      pre_q   <= '0;
      oc_q    <= '0;
      retry_q <= '0;
      sw_en   <= 1'b0;
      run     <= 1'b0;
      fault   <= 1'b0;
    end else begin
      state_q <= state_d;
      ss_code <= ss_d;
      deb_q   <= deb_d;
      pre_q   <= pre_d;
      oc_q    <= oc_d;
      retry_q <= retry_d;
      sw_en   <= (state_d == ST_SOFT) || (state_d == ST_RUN);
      run     <= (state_d == ST_RUN);
      fault   <= (state_d == ST_FAULT);
    end
  end

endmodule

// File: tb/tb_stepdown_corestate_seq.sv
// Self-checking bench for stepdown_corestate_seq: directed scenarios plus
// randomized traffic compared against an elapsed-time behavioural model.
module tb_stepdown_corestate_seq;

  localparam int SS_W        = 6;
  localparam int SS_STEP_DIV = 4;
  localparam int DEB_CYC     = 3;
  localparam int OC_LIMIT    = 4;
  localparam int RETRY_CYC   = 64;
  localparam int SS_MAX      = (1 << SS_W) - 1;
  localparam int SOFT_CLKS   = (1 << SS_W) * SS_STEP_DIV;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            CELV = 1'b1;
  logic            CELG = 1'b0;
  logic            SUB = 1'b0;
  logic            en = 1'b0;
  logic            uvlo_ok = 1'b0;
  logic            oc = 1'b0;
  logic [SS_W-1:0] ss_code;
  logic            sw_en;
  logic            run;
  logic            fault;
  logic [2:0]      state;

  int checks   = 0;
  int failures = 0;

  // Model: 0=OFF 1=SOFT 2=RUN 3=FAULT; m_t is clocks elapsed in SOFT or FAULT.
  int m_st  = 0;
  int m_deb = 0;
  int m_t   = 0;
  int m_oc  = 0;

  stepdown_corestate_seq #(
    .SS_W(SS_W), .SS_STEP_DIV(SS_STEP_DIV), .DEB_CYC(DEB_CYC),
    .OC_LIMIT(OC_LIMIT), .RETRY_CYC(RETRY_CYC)
  ) dut (
    .CLK(CLK), .RST(RST), .CELV(CELV), .CELG(CELG), .SUB(SUB),
    .en(en), .uvlo_ok(uvlo_ok), .oc(oc),
    .ss_code(ss_code), .sw_en(sw_en), .run(run), .fault(fault), .state(state)
  );

  always #5 CLK = ~CLK;

  function automatic void model_off();
    m_st = 0; m_deb = 0; m_t = 0; m_oc = 0;
  endfunction

  function automatic void model_step(input logic r, input logic e, input logic u, input logic o);
    logic qq;
    qq = e & u;
    if (r) begin
      model_off();
    end else if (m_st == 0) begin
      if (qq) begin
        m_deb++;
        if (m_deb == DEB_CYC) begin m_st = 1; m_deb = 0; m_t = 0; end
      end else begin
        m_deb = 0;
      end
    end else if (!qq) begin
      model_off();
    end else if (m_st == 3) begin
      m_t++;
      if (m_t == RETRY_CYC) model_off();
    end else begin
      m_oc = o ? m_oc + 1 : 0;
      if (m_oc == OC_LIMIT) begin
        m_st = 3; m_t = 0; m_oc = 0;
      end else if (m_st == 1) begin
        m_t++;
        if (m_t == SOFT_CLKS) m_st = 2;
      end
    end
  endfunction

  function automatic logic [SS_W+5:0] exp_vec();
    int lvl;
    lvl = 0;
    if (m_st == 1) lvl = (m_t / SS_STEP_DIV > SS_MAX) ? SS_MAX : m_t / SS_STEP_DIV;
    if (m_st == 2) lvl = SS_MAX;
    return {3'(m_st), SS_W'(lvl), (m_st == 1 || m_st == 2), (m_st == 2), (m_st == 3)};
  endfunction

  function automatic logic [SS_W+5:0] obs_vec();
    return {state, ss_code, sw_en, run, fault};
  endfunction

  task automatic tick();
    @(posedge CLK);
    model_step(RST, en, uvlo_ok, oc);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; en = 1'b0; uvlo_ok = 1'b0; oc = 1'b0;
    tick(); tick();
    RST = 1'b0;
  endtask

  task automatic goto_soft();
    en = 1'b1; uvlo_ok = 1'b1; oc = 1'b0;
    repeat (DEB_CYC) tick();
  endtask

  task automatic test_reset();
    RST = 1'b1; en = 1'b1; uvlo_ok = 1'b1; oc = 1'b1;
    tick(); tick();
    checks++;
    if (obs_vec() !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0", obs_vec());
    end
    do_reset();
  endtask

  task automatic test_debounce();
    do_reset();
    en = 1'b1; uvlo_ok = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (state !== ((i < 3) ? 3'd0 : 3'd1) || obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL debounce_edge%0d: got state=%0d vec=%h expected vec=%h", i, state, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (ss_code !== '0 || sw_en !== 1'b1 || run !== 1'b0) begin
      failures++;
      $display("FAIL debounce_soft_entry: got ss=%0d sw_en=%b run=%b expected 0 1 0", ss_code, sw_en, run);
    end
  endtask

  task automatic test_glitch();
    logic pat [6];
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    uvlo_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      en = pat[i];
      tick();
      checks++;
      if (state !== ((i == 5) ? 3'd1 : 3'd0) || obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL glitch_edge%0d: got state=%0d vec=%h expected vec=%h", i, state, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_ramp();
    int run_at;
    do_reset();
    goto_soft();
    run_at = -1;
    for (int k = 1; k <= SOFT_CLKS + 20 && run_at < 0; k++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL ramp_clk%0d: got %h expected %h", k, obs_vec(), exp_vec());
      end
      if (run === 1'b1) run_at = k;
    end
    checks++;
    if (run_at != 256) begin
      failures++;
      $display("FAIL ramp_dwell: got %0d clocks expected 256", run_at);
    end
    repeat (5) tick();
    checks++;
    if (state !== 3'd2 || ss_code !== 6'd63 || run !== 1'b1 || sw_en !== 1'b1) begin
      failures++;
      $display("FAIL ramp_hold: got state=%0d ss=%0d run=%b sw_en=%b expected 2 63 1 1", state, ss_code, run, sw_en);
    end
  endtask

  task automatic test_oc_hiccup();
    do_reset();
    goto_soft();
    repeat (SOFT_CLKS) tick();
    oc = 1'b1; repeat (3) tick();
    oc = 1'b0; tick();
    checks++;
    if (state !== 3'd2 || fault !== 1'b0 || obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL oc_three_cycles: got state=%0d fault=%b expected 2 0", state, fault);
    end
    oc = 1'b1; repeat (4) tick();
    oc = 1'b0;
    checks++;
    if (state !== 3'd3 || sw_en !== 1'b0 || fault !== 1'b1 || ss_code !== '0 || run !== 1'b0) begin
      failures++;
      $display("FAIL oc_trip: got state=%0d sw_en=%b fault=%b ss=%0d expected 3 0 1 0", state, sw_en, fault, ss_code);
    end
    for (int k = 1; k <= RETRY_CYC; k++) begin
      tick();
      checks++;
      if (state !== ((k < 64) ? 3'd3 : 3'd0) || obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL hiccup_clk%0d: got %h expected %h", k, obs_vec(), exp_vec());
      end
    end
    repeat (3) tick();
    checks++;
    if (state !== 3'd1 || ss_code !== '0 || sw_en !== 1'b1) begin
      failures++;
      $display("FAIL hiccup_redebounce: got state=%0d ss=%0d sw_en=%b expected 1 0 1", state, ss_code, sw_en);
    end
  endtask

  task automatic test_en_drop();
    do_reset();
    goto_soft();
    repeat (80) tick();
    checks++;
    if (ss_code !== 6'd20 || state !== 3'd1) begin
      failures++;
      $display("FAIL drop_pre_ss: got ss=%0d state=%0d expected 20 1", ss_code, state);
    end
    en = 1'b0; tick();
    checks++;
    if (state !== 3'd0 || ss_code !== '0 || sw_en !== 1'b0 || obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL drop_to_off: got state=%0d ss=%0d sw_en=%b expected 0 0 0", state, ss_code, sw_en);
    end
    goto_soft();
    repeat (4) tick();
    checks++;
    if (state !== 3'd1 || ss_code !== 6'd1 || obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL drop_restart: got state=%0d ss=%0d expected 1 1", state, ss_code);
    end
  endtask

  task automatic test_oc_final_step();
    bit saw_run;
    do_reset();
    goto_soft();
    saw_run = 0;
    for (int k = 1; k <= SOFT_CLKS + 4; k++) begin
      oc = (k > SOFT_CLKS - OC_LIMIT && k <= SOFT_CLKS);
      tick();
      if (run === 1'b1) saw_run = 1;
      if (k == SOFT_CLKS) begin
        checks++;
        if (state !== 3'd3 || fault !== 1'b1 || obs_vec() !== exp_vec()) begin
          failures++;
          $display("FAIL oc_final_step: got state=%0d fault=%b expected 3 1", state, fault);
        end
      end
    end
    oc = 1'b0;
    checks++;
    if (saw_run) begin
      failures++;
      $display("FAIL oc_final_run: got run asserted expected never");
    end
  endtask

  task automatic test_rst_fault();
    do_reset();
    goto_soft();
    oc = 1'b1; repeat (OC_LIMIT) tick();
    oc = 1'b0; repeat (10) tick();
    RST = 1'b1; tick(); RST = 1'b0;
    checks++;
    if (state !== 3'd0 || fault !== 1'b0 || obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL rst_mid_fault: got state=%0d fault=%b expected 0 0", state, fault);
    end
  endtask

  task automatic test_random();
    int oc_pct;
    do_reset();
    for (int k = 0; k < 6000; k++) begin
      oc_pct  = (k < 3000) ? 3 : 35;
      RST     = ($urandom_range(0, 999) < 2);
      en      = ($urandom_range(0, 999) < 995);
      uvlo_ok = ($urandom_range(0, 999) < 997);
      oc      = ($urandom_range(0, 99) < oc_pct);
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random_clk%0d: got %h expected %h", k, obs_vec(), exp_vec());
      end
    end
    RST = 1'b0;
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_glitch();
    test_ramp();
    test_oc_hiccup();
    test_en_drop();
    test_oc_final_step();
    test_rst_fault();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
